// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Summary  : UART state encodings and parity-mode constants shared by TX/RX.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY_S = 3'd3,
    STOP     = 3'd4
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } uart_parity_e;

  // Parity bit for a frame given the payload's XOR reduction.
  function automatic logic parity_bit(input uart_parity_e mode, input logic xor_red);
    return (mode == PAR_ODD) ? ~xor_red : xor_red;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Summary  : Per-bit timer; tick is high once every BAUD_DIV cycles.
// Revision : 1.0
// ============================================================================
module uart_baud_gen #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int                 c_CNT_W    = $clog2(BAUD_DIV) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BAUD_DIV - 1);

  logic [c_CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == c_CNT_LAST);

  // Wrapping on tick keeps every bit boundary aligned to a zero count.
  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + c_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_xmit.sv
`default_nettype none
// ============================================================================
// Module   : uart_xmit
// Summary  : AXI-Stream fed UART transmitter, optional parity.
//            Define UART_XMIT_STOP2_EN for two stop bits.
// Revision : 1.0
// ============================================================================
module uart_xmit
  import uart_pkg::*;
#(
  parameter int    CLK_FREQ  = 50_000_000,
  parameter int    BAUD      = 115200,
  parameter int    DATA_BITS = 8,
  parameter string PARITY    = "even"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int                  BAUD_DIV   = CLK_FREQ / BAUD;
  localparam int                  c_BCNT_W   = $clog2(DATA_BITS) + 1;
  localparam logic [c_BCNT_W-1:0] c_LAST_BIT = c_BCNT_W'(DATA_BITS - 1);
  localparam uart_parity_e        c_PAR_MODE = (PARITY == "none") ? PAR_NONE :
                                               (PARITY == "odd")  ? PAR_ODD  : PAR_EVEN;
`ifdef UART_XMIT_STOP2_EN
  localparam logic                c_STOP_LAST = 1'b1;
`else
  localparam logic                c_STOP_LAST = 1'b0;
`endif

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [c_BCNT_W-1:0]  bit_cnt_q;
  logic                 parity_q;
  logic                 stop_cnt_q;
  logic                 tready_q;
  logic                 tx_q;
  logic                 busy_q;

  logic                 w_tick;
  logic                 w_clear;
  logic                 w_accept;
  logic                 w_parity;

  assign w_clear  = (state_q == IDLE);
  assign w_accept = tready_q && s_axis_tvalid;
  assign w_parity = parity_bit(c_PAR_MODE, ^s_axis_tdata);

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      parity_q   <= 1'b0;
      stop_cnt_q <= 1'b0;
      tready_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (w_accept) begin
            shift_q    <= s_axis_tdata;
            parity_q   <= w_parity;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tready_q   <= 1'b0;
            busy_q     <= 1'b1;
            tx_q       <= 1'b0;
            state_q    <= START;
          end else begin
            tready_q   <= 1'b1;
          end
        end

        START: begin
          if (w_tick) begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end

        // bit_cnt_q names the data bit currently on the line.
        DATA: begin
          if (w_tick) begin
            if (bit_cnt_q == c_LAST_BIT) begin
              bit_cnt_q <= '0;
              if (c_PAR_MODE == PAR_NONE) begin
                tx_q       <= 1'b1;
                stop_cnt_q <= 1'b0;
                state_q    <= STOP;
              end else begin
                tx_q       <= parity_q;
                state_q    <= PARITY_S;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + c_BCNT_W'(1);
            end
          end
        end

        PARITY_S: begin
          if (w_tick) begin
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= STOP;
          end
        end

        STOP: begin
          if (w_tick) begin
            if (stop_cnt_q == c_STOP_LAST) begin
              stop_cnt_q <= 1'b0;
              tready_q   <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end

        default: begin
          tx_q     <= 1'b1;
          tready_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign tx            = tx_q;
  assign tx_busy       = busy_q;

endmodule
`default_nettype wire
